mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the execute ALU result (effective address or pass-through result), store data, destination register and write-enable.
- Performs RV32I loads and stores against a single-port data-memory handshake, then presents a registered writeback bundle to the register-file write stage.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 19 +
 rtl/mem_access_stage_if.sv | 42 ++++
 rtl/mem_access_stage_lane_align.sv | 48 ++++
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared funct3 codes and FSM state encoding for the memory-access stage.
package mem_access_stage_pkg;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMemReq  = 2'd1,
        StMemWait = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Execute-bundle, data-memory and writeback signals of the memory-access stage.
interface mem_access_stage_if;

    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd;
    logic        i_write_reg;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_wb_valid;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_bus_error;

    modport slave (
        input  i_valid, i_load, i_store, i_funct3, i_alu_result, i_store_data, i_rd,
               i_write_reg, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
               o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_misaligned, o_bus_error
    );

    modport master (
        output i_valid, i_load, i_store, i_funct3, i_alu_result, i_store_data, i_rd,
               i_write_reg, i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
               o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_misaligned, o_bus_error
    );

endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Combinational byte-lane logic: store enables/replication, load extract/extend, alignment.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        unique case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        unique case (funct3)
            F3Lb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3Lh:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3Lbu:   load_data = {24'd0, shifted[7:0]};
            F3Lhu:   load_data = {16'd0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access pipeline stage: issues loads/stores on a single-port memory handshake
// and produces a registered one-cycle writeback pulse per retired op.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned N_param        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned debug_param    = 1
) (
    input logic                i_clk,
    input logic                i_rst,
    mem_access_stage_if.slave  bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q;
    logic                 store_q;
    logic [2:0]           f3_q;
    logic [N_param-1:0]   addr_q;
    logic [N_param-1:0]   sdata_q;
    logic [4:0]           rd_q;
    logic [CntW-1:0]      cnt_q;

    logic                 wb_valid_q;
    logic                 wb_we_q;
    logic [4:0]           wb_rd_q;
    logic [N_param-1:0]   wb_data_q;
    logic                 mis_q;
    logic                 berr_q;

    logic                 idle;
    logic                 is_mem;
    logic [2:0]           sel_f3;
    logic [1:0]           sel_addr_lo;
    logic [N_param-1:0]   sel_sdata;
    logic [3:0]           lane_be;
    logic [N_param-1:0]   lane_wdata;
    logic [N_param-1:0]   load_data;
    logic                 misaligned;
    logic                 mem_req;
    logic                 load_done;
    logic                 store_done;
    logic                 timeout_hit;

    // One lane aligner serves both the incoming bundle (alignment check in idle)
    // and the latched bundle (lanes and load extraction while a transaction is open).
    always_comb begin
        idle        = (state_q == StIdle);
        is_mem      = bus.i_load | bus.i_store;
        sel_f3      = idle ? bus.i_funct3 : f3_q;
        sel_addr_lo = idle ? bus.i_alu_result[1:0] : addr_q[1:0];
        sel_sdata   = idle ? bus.i_store_data : sdata_q;
    end

    mem_lane_align u_lane_align (
        .funct3     (sel_f3),
        .addr_lo    (sel_addr_lo),
        .store_data (sel_sdata),
        .rdata      (bus.i_mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    always_comb begin
        mem_req     = (state_q == StMemReq);
        store_done  = mem_req & bus.i_mem_ready & store_q;
        load_done   = (mem_req & bus.i_mem_ready & bus.i_mem_rvalid & ~store_q) |
                      ((state_q == StMemWait) & bus.i_mem_rvalid);
        timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    end

    assign bus.o_stall      = ~idle | (bus.i_valid & is_mem & ~misaligned);
    assign bus.o_mem_req    = mem_req;
    assign bus.o_mem_we     = mem_req & store_q;
    assign bus.o_mem_addr   = mem_req ? {addr_q[N_param-1:2], 2'b00} : '0;
    assign bus.o_mem_be     = mem_req ? lane_be : 4'b0000;
    assign bus.o_mem_wdata  = (mem_req & store_q) ? lane_wdata : '0;
    assign bus.o_wb_valid   = wb_valid_q;
    assign bus.o_wb_we      = wb_we_q;
    assign bus.o_wb_rd      = wb_rd_q;
    assign bus.o_wb_data    = wb_data_q;
    assign bus.o_misaligned = mis_q;
    assign bus.o_bus_error  = berr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            store_q    <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= 5'd0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (bus.i_valid) begin
                        wb_rd_q   <= bus.i_rd;
                        wb_data_q <= bus.i_alu_result;
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= bus.i_write_reg & (bus.i_rd != 5'd0);
                        end else if (misaligned) begin
                            wb_valid_q <= 1'b1;
                            mis_q      <= 1'b1;
                        end else begin
                            store_q <= bus.i_store;
                            f3_q    <= bus.i_funct3;
                            addr_q  <= bus.i_alu_result;
                            sdata_q <= bus.i_store_data;
                            rd_q    <= bus.i_rd;
                            state_q <= StMemReq;
                        end
                    end
                end
                StMemReq, StMemWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A completing handshake wins over a coincident timeout.
                    if (load_done) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= (rd_q != 5'd0);
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= load_data;
                        state_q    <= StIdle;
                    end else if (store_done) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        state_q    <= StIdle;
                    end else if (timeout_hit) begin
                        wb_valid_q <= 1'b1;
                        berr_q     <= 1'b1;
                        wb_rd_q    <= rd_q;
                        state_q    <= StIdle;
                    end else if (mem_req && bus.i_mem_ready) begin
                        state_q <= StMemWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    generate
        if (debug_param != 0) begin : g_trace
`ifndef SYNTHESIS
            always @(posedge i_clk) begin
                if (!i_rst && wb_valid_q) begin
                    $write("mem_access_stage: rd=%0d we=%0b data=%08h mis=%0b berr=%0b\n",
                           wb_rd_q, wb_we_q, wb_data_q, mis_q, berr_q);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_access_stage_if bus ();

    mem_access_stage #(
        .N_param        (32),
        .TIMEOUT_CYCLES (8),
        .debug_param    (0)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic        load;
        logic        store;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        wreg;
        logic        exp_wb_valid;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_t;

    vec_t vecs[8];
    ld_t  lds[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_valid      = 1'b0;
        bus.i_load       = 1'b0;
        bus.i_store      = 1'b0;
        bus.i_funct3     = 3'b000;
        bus.i_alu_result = 32'd0;
        bus.i_store_data = 32'd0;
        bus.i_rd         = 5'd0;
        bus.i_write_reg  = 1'b0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'd0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
        bus.i_valid      = 1'b1;
        bus.i_load       = ld;
        bus.i_store      = st;
        bus.i_funct3     = f3;
        bus.i_alu_result = alu;
        bus.i_store_data = sd;
        bus.i_rd         = rd;
        bus.i_write_reg  = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00AA, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0105, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0042, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0201, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0302, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0777, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0};

        lds[0] = '{3'b100, 32'h0000_0101, 32'h80FF_FF7F, 32'h0000_00FF};
        lds[1] = '{3'b101, 32'h0000_0102, 32'h80FF_FF7F, 32'h0000_80FF};
        lds[2] = '{3'b001, 32'h0000_0100, 32'h1234_8001, 32'hFFFF_8001};
        lds[3] = '{3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_wb_valid", {31'd0, bus.o_wb_valid}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.o_mem_req}, 32'd0);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("rst_wb_data", bus.o_wb_data, 32'd0);
        chk("rst_flags", {30'd0, bus.o_misaligned, bus.o_bus_error}, 32'd0);
        rst = 1'b0;
        tick();

        // Single-cycle ops back to back, one retire per cycle.
        for (int i = 0; i < 8; i++) begin
            bus.i_valid      = vecs[i].valid;
            bus.i_load       = vecs[i].load;
            bus.i_store      = vecs[i].store;
            bus.i_funct3     = vecs[i].f3;
            bus.i_alu_result = vecs[i].alu;
            bus.i_rd         = vecs[i].rd;
            bus.i_write_reg  = vecs[i].wreg;
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, bus.o_stall}, 32'd0);
            tick();
            chk($sformatf("vec%0d_wb_valid", i), {31'd0, bus.o_wb_valid},
                {31'd0, vecs[i].exp_wb_valid});
            chk($sformatf("vec%0d_mem_req", i), {31'd0, bus.o_mem_req}, 32'd0);
            if (vecs[i].exp_wb_valid) begin
                chk($sformatf("vec%0d_we", i), {31'd0, bus.o_wb_we}, {31'd0, vecs[i].exp_we});
                chk($sformatf("vec%0d_mis", i), {31'd0, bus.o_misaligned},
                    {31'd0, vecs[i].exp_mis});
                chk($sformatf("vec%0d_rd", i), {27'd0, bus.o_wb_rd}, {27'd0, vecs[i].rd});
                if (!vecs[i].exp_mis)
                    chk($sformatf("vec%0d_data", i), bus.o_wb_data, vecs[i].alu);
            end
        end
        idle_inputs();
        tick();

        // LB 0x103: ready in request cycle, rvalid one cycle later.
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd9);
        #1;
        chk("lb_stall_c0", {31'd0, bus.o_stall}, 32'd1);
        chk("lb_req_c0", {31'd0, bus.o_mem_req}, 32'd0);
        tick();
        idle_inputs();
        chk("lb_req_c1", {31'd0, bus.o_mem_req}, 32'd1);
        chk("lb_addr", bus.o_mem_addr, 32'h0000_0100);
        chk("lb_we", {31'd0, bus.o_mem_we}, 32'd0);
        chk("lb_stall_c1", {31'd0, bus.o_stall}, 32'd1);
        bus.i_mem_ready = 1'b1;
        tick();
        bus.i_mem_ready = 1'b0;
        chk("lb_req_c2", {31'd0, bus.o_mem_req}, 32'd0);
        chk("lb_stall_c2", {31'd0, bus.o_stall}, 32'd1);
        chk("lb_wb_early", {31'd0, bus.o_wb_valid}, 32'd0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h80FF_FF7F;
        tick();
        idle_inputs();
        chk("lb_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);
        chk("lb_wb_we", {31'd0, bus.o_wb_we}, 32'd1);
        chk("lb_wb_rd", {27'd0, bus.o_wb_rd}, 32'd9);
        chk("lb_wb_data", bus.o_wb_data, 32'hFFFF_FF80);
        chk("lb_stall_done", {31'd0, bus.o_stall}, 32'd0);

        // Loads completing with ready and rvalid in the same cycle.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, lds[i].f3, lds[i].addr, 32'd0, 5'd12);
            tick();
            idle_inputs();
            chk($sformatf("ld%0d_addr", i), bus.o_mem_addr, {lds[i].addr[31:2], 2'b00});
            bus.i_mem_ready  = 1'b1;
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = lds[i].rdata;
            tick();
            idle_inputs();
            chk($sformatf("ld%0d_wb_valid", i), {31'd0, bus.o_wb_valid}, 32'd1);
            chk($sformatf("ld%0d_data", i), bus.o_wb_data, lds[i].exp);
        end

        // SH 0xABCD at 0x202 with ready delayed two cycles.
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd0);
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("sh_req_c%0d", c), {31'd0, bus.o_mem_req}, 32'd1);
            chk($sformatf("sh_be_c%0d", c), {28'd0, bus.o_mem_be}, 32'h0000_000C);
            chk($sformatf("sh_wdata_c%0d", c), bus.o_mem_wdata, 32'hABCD_ABCD);
            chk($sformatf("sh_addr_c%0d", c), bus.o_mem_addr, 32'h0000_0200);
            chk($sformatf("sh_we_c%0d", c), {31'd0, bus.o_mem_we}, 32'd1);
            if (c == 2) bus.i_mem_ready = 1'b1;
            tick();
        end
        idle_inputs();
        chk("sh_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);
        chk("sh_wb_we", {31'd0, bus.o_wb_we}, 32'd0);
        chk("sh_req_done", {31'd0, bus.o_mem_req}, 32'd0);

        // SB 0x5A at 0x301.
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 5'd0);
        tick();
        idle_inputs();
        chk("sb_be", {28'd0, bus.o_mem_be}, 32'h0000_0002);
        chk("sb_wdata", bus.o_mem_wdata, 32'h5A5A_5A5A);
        bus.i_mem_ready = 1'b1;
        tick();
        idle_inputs();
        chk("sb_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);

        // Load that is never accepted: bus error after 8 cycles in the request state.
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd3);
        tick();
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("to_req_c%0d", c), {31'd0, bus.o_mem_req}, 32'd1);
            tick();
        end
        chk("to_wb_valid", {31'd0, bus.o_wb_valid}, 32'd1);
        chk("to_bus_error", {31'd0, bus.o_bus_error}, 32'd1);
        chk("to_wb_we", {31'd0, bus.o_wb_we}, 32'd0);
        chk("to_req_drop", {31'd0, bus.o_mem_req}, 32'd0);
        chk("to_stall", {31'd0, bus.o_stall}, 32'd0);
        issue(1'b0, 1'b0, 3'b000, 32'h0000_5555, 32'd0, 5'd2);
        tick();
        idle_inputs();
        chk("to_then_alu", bus.o_wb_data, 32'h0000_5555);

        // rvalid without ready in the request state is ignored.
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0, 5'd4);
        tick();
        idle_inputs();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hBAD0_BAD0;
        tick();
        bus.i_mem_rvalid = 1'b0;
        chk("ign_req", {31'd0, bus.o_mem_req}, 32'd1);
        chk("ign_wb", {31'd0, bus.o_wb_valid}, 32'd0);
        bus.i_mem_ready = 1'b1;
        tick();
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h1122_3344;
        tick();
        idle_inputs();
        chk("ign_data", bus.o_wb_data, 32'h1122_3344);

        // Reset during the wait state, then a late rvalid.
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 5'd3);
        tick();
        idle_inputs();
        bus.i_mem_ready = 1'b1;
        tick();
        bus.i_mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_req", {31'd0, bus.o_mem_req}, 32'd0);
        chk("rstw_wb", {31'd0, bus.o_wb_valid}, 32'd0);
        chk("rstw_stall", {31'd0, bus.o_stall}, 32'd0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h7777_7777;
        tick();
        idle_inputs();
        chk("rstw_late_wb", {31'd0, bus.o_wb_valid}, 32'd0);
        tick();
        chk("rstw_late_wb2", {31'd0, bus.o_wb_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
